// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: two-way icache refill engine; fetches a line from L2 and writes the victim way's data and tag for one cycle
module icache_fill_ctrl #(
  parameter int TAG_W = 20,
  parameter int INDEX_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               miss_req,
  input  logic [31:0]        miss_addr,
  input  logic               valid0,
  input  logic               valid1,
  input  logic               lru,
  output logic               busy,
  output logic               l2_req,
  output logic [27:0]        l2_addr,
  input  logic               l2_ack,
  input  logic               l2_rvalid,
  input  logic [127:0]       l2_rdata,
  output logic               block0_we,
  output logic               block1_we,
  output logic [INDEX_W-1:0] index,
  output logic [127:0]       data_wd,
  output logic               tag_we0,
  output logic               tag_we1,
  output logic [TAG_W:0]     tag_wd,
  output logic               fill_done,
  output logic               fill_way
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE} state_t;
  state_t state;
  logic victim, go_write, unused_ok;
  assign victim = !valid0 ? 1'b0 : !valid1 ? 1'b1 : lru;
  // data may arrive with the ack itself, skipping WAIT
  assign go_write = (state == REQ && l2_ack && l2_rvalid) || (state == WAIT && l2_rvalid);
  assign unused_ok = ^miss_addr[3:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      l2_req <= 1'b0;
      l2_addr <= '0;
      block0_we <= 1'b0;
      block1_we <= 1'b0;
      tag_we0 <= 1'b0;
      tag_we1 <= 1'b0;
      index <= '0;
      data_wd <= '0;
      tag_wd <= '0;
      fill_done <= 1'b0;
      fill_way <= 1'b0;
    end else begin
      block0_we <= 1'b0;
      block1_we <= 1'b0;
      tag_we0 <= 1'b0;
      tag_we1 <= 1'b0;
      fill_done <= 1'b0;
      if (go_write) begin
        state <= WRITE;
        l2_req <= 1'b0;
        data_wd <= l2_rdata;
        block0_we <= !fill_way;
        tag_we0 <= !fill_way;
        block1_we <= fill_way;
        tag_we1 <= fill_way;
      end else begin
        case (state)
          IDLE: if (miss_req) begin
            state <= REQ;
            busy <= 1'b1;
            l2_req <= 1'b1;
            l2_addr <= miss_addr[31:4];
            index <= miss_addr[4 +: INDEX_W];
            tag_wd <= {1'b1, miss_addr[31 -: TAG_W]};
            fill_way <= victim;
          end
          REQ: if (l2_ack) begin
            state <= WAIT;
            l2_req <= 1'b0;
          end
          WAIT: state <= WAIT;
          WRITE: begin
            state <= DONE;
            fill_done <= 1'b1;
          end
          DONE: begin
            state <= IDLE;
            busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb_icache_fill_ctrl: scoreboard bench for the icache refill engine
module tb_icache_fill_ctrl;
  logic clk = 0, rst = 1;
  logic miss_req = 0, valid0 = 0, valid1 = 0, lru = 0;
  logic [31:0] miss_addr = 0;
  logic l2_ack = 0, l2_rvalid = 0;
  logic [127:0] l2_rdata = 0;
  logic busy, l2_req, block0_we, block1_we, tag_we0, tag_we1, fill_done, fill_way;
  logic [27:0] l2_addr;
  logic [7:0] index;
  logic [127:0] data_wd;
  logic [20:0] tag_wd;
  int checks = 0, failures = 0;

  icache_fill_ctrl dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .valid0(valid0), .valid1(valid1), .lru(lru), .busy(busy),
    .l2_req(l2_req), .l2_addr(l2_addr), .l2_ack(l2_ack), .l2_rvalid(l2_rvalid),
    .l2_rdata(l2_rdata), .block0_we(block0_we), .block1_we(block1_we),
    .index(index), .data_wd(data_wd), .tag_we0(tag_we0), .tag_we1(tag_we1),
    .tag_wd(tag_wd), .fill_done(fill_done), .fill_way(fill_way)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic way;
    logic [7:0] idx;
    logic [20:0] tag;
    logic [27:0] l2a;
    logic [127:0] data;
    int wc, dc, rl;
  } exp_t;
  exp_t sb[$];

  int w_cyc, w_cnt, d_cyc, req_last;
  logic w_way, w_bad, busy_bad, idle_busy, d_way;
  logic [7:0] w_idx;
  logic [20:0] w_tag;
  logic [127:0] w_data;
  logic [27:0] w_l2a;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one miss in an IDLE cycle, pushes the expected write, and records what the DUT does until fill_done
  task automatic fill(input logic [31:0] a, input logic v0, v1, lr, input int ad, rd,
                      input logic [127:0] d, input bit toggle, stray);
    exp_t e;
    tick();
    idle_busy = busy;
    miss_req = 1; miss_addr = a; valid0 = v0; valid1 = v1; lru = lr;
    e.way = !v0 ? 1'b0 : !v1 ? 1'b1 : lr;
    e.idx = a[11:4]; e.tag = {1'b1, a[31:12]}; e.l2a = a[31:4]; e.data = d;
    e.wc = rd + 1; e.dc = rd + 2; e.rl = ad;
    sb.push_back(e);
    w_cyc = -1; w_cnt = 0; d_cyc = -1; req_last = -1; w_bad = 0; busy_bad = 0;
    for (int k = 1; k <= 60 && d_cyc < 0; k++) begin
      tick();
      if (l2_req) req_last = k;
      if (!busy) busy_bad = 1;
      if (block0_we | block1_we | tag_we0 | tag_we1) begin
        w_cnt++;
        if (w_cyc < 0) w_cyc = k;
        w_way = block1_we;
        w_bad = w_bad | (block0_we != tag_we0) | (block1_we != tag_we1) | (block0_we & block1_we);
        w_idx = index; w_tag = tag_wd; w_data = data_wd; w_l2a = l2_addr;
      end
      if (fill_done) begin d_cyc = k; d_way = fill_way; end
      l2_ack = (k == ad);
      l2_rvalid = (k == rd) || (stray && k == 1);
      l2_rdata = (k == rd) ? d : {$urandom(), $urandom(), $urandom(), $urandom()};
      miss_req = (d_cyc < 0) && (!toggle || k[0]);
      miss_addr = toggle ? $urandom() : a;
    end
    l2_ack = 0; l2_rvalid = 0; miss_req = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    checks++;
    if ({busy, l2_req, block0_we, block1_we, tag_we0, tag_we1, fill_done, fill_way} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000000", {busy, l2_req, block0_we, block1_we, tag_we0, tag_we1, fill_done, fill_way});
    end
    checks++;
    if ({l2_addr, index, data_wd, tag_wd} !== '0) begin
      failures++;
      $display("FAIL reset_data l2_addr=%h index=%h tag_wd=%h data_wd=%h exp=0", l2_addr, index, tag_wd, data_wd);
    end
    rst = 0;
  endtask

  task automatic test_basic();
    exp_t e;
    fill(32'h0000_1230, 0, 0, 0, 2, 4, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 0, 0);
    if (sb.size() == 0) begin failures++; $display("FAIL basic_sb queue empty"); return; end
    e = sb.pop_front();
    checks++;
    if (idle_busy !== 1'b0) begin failures++; $display("FAIL basic_idle busy=%b exp=0", idle_busy); end
    checks++;
    if (w_l2a !== 28'h0000123 || w_l2a !== e.l2a) begin failures++; $display("FAIL basic_l2addr got=%h exp=%h", w_l2a, e.l2a); end
    checks++;
    if (w_cyc !== e.wc || w_cnt !== 1) begin failures++; $display("FAIL basic_wcyc got=%0d cnt=%0d exp=%0d cnt=1", w_cyc, w_cnt, e.wc); end
    checks++;
    if (w_way !== e.way || w_bad !== 1'b0) begin failures++; $display("FAIL basic_way got=%b bad=%b exp=%b", w_way, w_bad, e.way); end
    checks++;
    if (w_idx !== 8'h23 || w_tag !== 21'h100001) begin failures++; $display("FAIL basic_idxtag got=%h/%h exp=23/100001", w_idx, w_tag); end
    checks++;
    if (w_data !== e.data) begin failures++; $display("FAIL basic_data got=%h exp=%h", w_data, e.data); end
    checks++;
    if (d_cyc !== e.dc || d_way !== 1'b0) begin failures++; $display("FAIL basic_done got=%0d way=%b exp=%0d way=0", d_cyc, d_way, e.dc); end
    checks++;
    if (req_last !== e.rl || busy_bad !== 1'b0) begin failures++; $display("FAIL basic_req last=%0d busy_bad=%b exp=%0d/0", req_last, busy_bad, e.rl); end
  endtask

  task automatic test_victim();
    logic [2:0] pat [3] = '{3'b100, 3'b111, 3'b110};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      fill(32'h4000_0000 + 32'(i) * 32'h1010, pat[i][2], pat[i][1], pat[i][0], 1, 2,
           {4{$urandom()}}, 0, 0);
      if (sb.size() == 0) begin failures++; $display("FAIL victim_sb queue empty"); return; end
      e = sb.pop_front();
      checks++;
      if (w_way !== e.way || w_bad !== 1'b0 || w_cnt !== 1) begin
        failures++;
        $display("FAIL victim_%0d way=%b bad=%b cnt=%0d exp way=%b bad=0 cnt=1", i, w_way, w_bad, w_cnt, e.way);
      end
      checks++;
      if (d_way !== e.way || w_idx !== e.idx) begin failures++; $display("FAIL victim_fw_%0d got=%b idx=%h exp=%b idx=%h", i, d_way, w_idx, e.way, e.idx); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      fill(32'hABCD_E000 + 32'(i) * 32'h50, 1, 1, 1'(i), 1, 1, {4{$urandom()}}, 0, 0);
      if (sb.size() == 0) begin failures++; $display("FAIL b2b_sb queue empty"); return; end
      e = sb.pop_front();
      checks++;
      if (w_cyc !== 2 || d_cyc !== 3 || idle_busy !== 1'b0) begin
        failures++;
        $display("FAIL b2b_%0d wcyc=%0d dcyc=%0d idle_busy=%b exp 2/3/0", i, w_cyc, d_cyc, idle_busy);
      end
      checks++;
      if (w_data !== e.data || w_way !== e.way || w_tag !== e.tag) begin
        failures++;
        $display("FAIL b2b_data_%0d data=%h way=%b tag=%h exp=%h/%b/%h", i, w_data, w_way, w_tag, e.data, e.way, e.tag);
      end
    end
  endtask

  task automatic test_miss_busy();
    exp_t e;
    fill(32'h1234_5670, 0, 1, 1, 2, 6, {4{$urandom()}}, 1, 0);
    if (sb.size() == 0) begin failures++; $display("FAIL busy_sb queue empty"); return; end
    e = sb.pop_front();
    checks++;
    if (w_l2a !== e.l2a || w_idx !== e.idx || w_tag !== e.tag) begin
      failures++;
      $display("FAIL busy_hold l2a=%h idx=%h tag=%h exp=%h/%h/%h", w_l2a, w_idx, w_tag, e.l2a, e.idx, e.tag);
    end
    checks++;
    if (w_cnt !== 1 || w_cyc !== e.wc) begin failures++; $display("FAIL busy_writes cnt=%0d cyc=%0d exp=1/%0d", w_cnt, w_cyc, e.wc); end
  endtask

  task automatic test_stray();
    exp_t e;
    fill(32'h0F0F_0F00, 1, 0, 0, 3, 4, {4{$urandom()}}, 0, 1);
    if (sb.size() == 0) begin failures++; $display("FAIL stray_sb queue empty"); return; end
    e = sb.pop_front();
    checks++;
    if (req_last !== 3 || w_cyc !== e.wc || w_cnt !== 1) begin
      failures++;
      $display("FAIL stray_req last=%0d wcyc=%0d cnt=%0d exp=3/%0d/1", req_last, w_cyc, w_cnt, e.wc);
    end
    checks++;
    if (w_data !== e.data) begin failures++; $display("FAIL stray_data got=%h exp=%h", w_data, e.data); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    tick();
    miss_req = 1; miss_addr = 32'h7777_7770; valid0 = 1; valid1 = 0; lru = 0;
    tick(); l2_ack = 1;
    tick(); l2_ack = 0;
    tick(); l2_rvalid = 1; l2_rdata = {4{32'h5A5A_5A5A}}; rst = 1;
    tick(); l2_rvalid = 0; rst = 0; miss_req = 0;
    checks++;
    if ({busy, l2_req, block0_we, block1_we, tag_we0, tag_we1, fill_done, fill_way} !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_ctrl got=%b exp=00000000", {busy, l2_req, block0_we, block1_we, tag_we0, tag_we1, fill_done, fill_way});
    end
    checks++;
    if ({l2_addr, index, data_wd, tag_wd} !== '0) begin
      failures++;
      $display("FAIL rstmid_data l2_addr=%h index=%h tag_wd=%h exp=0", l2_addr, index, tag_wd);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      pulses += int'(block0_we | block1_we | tag_we0 | tag_we1 | fill_done | busy);
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL rstmid_pulses got=%0d exp=0", pulses); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_victim();
    test_back_to_back();
    test_miss_busy();
    test_stray();
    test_reset_mid();
    test_basic();
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL sb_left got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
